board_render: RTL and testbench

- Tile-based renderer for the pushbox play field. Walks a 20x15 tile map held in an external synchronous map RAM and expands each tile code into an 8x8 pixel sprite.
- Emits a 160x120, 3-bit-colour pixel-write stream (x, y, colour, writeEn). This stream is the in-game input of the picture selector, which forwards it to the VGA adapter while gaming=1.
- Supports full-frame redraw and queued single-tile redraw, the latter used after each player move.

---
 rtl/board_render_if.sv | 26 ++
 rtl/board_render.sv | 203 ++++++++++++++++++++
 tb/tb_board_render.sv | 406 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/board_render_if.sv
// Request, map-RAM and pixel-stream signals of the pushbox tile renderer.
interface board_render_if;
    logic       start;
    logic       tile_req;
    logic [4:0] tile_x;
    logic [3:0] tile_y;
    logic [8:0] map_addr;
    logic [2:0] map_data;
    logic [7:0] x_out;
    logic [6:0] y_out;
    logic [2:0] colour_out;
    logic       writeEn_out;
    logic       busy;
    logic       done;
    logic       req_drop;

    modport slave (
        input  start, tile_req, tile_x, tile_y, map_data,
        output map_addr, x_out, y_out, colour_out, writeEn_out, busy, done, req_drop
    );

    modport master (
        output start, tile_req, tile_x, tile_y, map_data,
        input  map_addr, x_out, y_out, colour_out, writeEn_out, busy, done, req_drop
    );
endinterface

// File: rtl/board_render.sv
// Tile-map walker: reads tile codes from the map RAM and expands each into an
// 8x8 sprite on a 160x120 pixel-write stream; full-frame and single-tile jobs.
module board_render #(
    parameter int COLS = 20,
    parameter int ROWS = 15
) (
    input  logic          clk50M,
    input  logic          rst_n,
    board_render_if.slave bus
);
    // state | meaning
    // IDLE  | no job; accepts start or tile_req
    // FETCH | map_addr presented to the map RAM
    // WAIT  | RAM read in flight; tile code latched at the end
    // DRAW  | 64 sprite pixels, one per cycle
    // DONE  | job finished; chain the pending tile or go idle
    typedef enum logic [2:0] {IDLE, FETCH, WAIT, DRAW, DONE} state_t;

    state_t     state_q, state_d;
    logic [4:0] tx_q, tx_d, pend_x_q, pend_x_d;
    logic [3:0] ty_q, ty_d, pend_y_q, pend_y_d;
    logic [2:0] ox_q, ox_d, oy_q, oy_d;
    logic [2:0] code_q, code_d;
    logic       frame_q, frame_d;
    logic       pend_q, pend_d;
    logic [8:0] map_addr_q, map_addr_d;
    logic [7:0] x_q, x_d;
    logic [6:0] y_q, y_d;
    logic [2:0] colour_q, colour_d;
    logic       we_q, we_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       drop_q, drop_d;
    logic       req_ok, last_tile;

    function automatic logic [8:0] tile_addr(input logic [4:0] x, input logic [3:0] y);
        return 9'(y) * 9'(COLS) + 9'(x);
    endfunction

    function automatic logic [2:0] sprite(input logic [2:0] code, input logic [2:0] ox,
                                          input logic [2:0] oy);
        logic       rim, centre, body;
        logic [2:0] c;
        rim    = (ox == 3'd0) || (ox == 3'd7) || (oy == 3'd0) || (oy == 3'd7);
        centre = (ox >= 3'd3) && (ox <= 3'd4) && (oy >= 3'd3) && (oy <= 3'd4);
        body   = (ox >= 3'd2) && (ox <= 3'd5) && (oy >= 3'd2) && (oy <= 3'd5);
        c = 3'b101;
        case (code)
            3'd0:    c = 3'b000;
            3'd1:    c = ((oy == 3'd3) || (oy == 3'd7)) ? 3'b111 : 3'b100;
            3'd2:    c = centre ? 3'b110 : 3'b000;
            3'd3:    c = rim ? 3'b111 : 3'b110;
            3'd4:    c = rim ? 3'b111 : 3'b010;
            3'd5:    c = body ? 3'b001 : 3'b000;
            3'd6:    c = body ? 3'b011 : 3'b000;
            default: c = 3'b101;
        endcase
        return c;
    endfunction

    assign req_ok    = bus.tile_req && (bus.tile_x < 5'(COLS)) && (bus.tile_y < 4'(ROWS));
    assign last_tile = (tx_q == 5'(COLS - 1)) && (ty_q == 4'(ROWS - 1));

    always_comb begin
        state_d    = state_q;
        tx_d       = tx_q;
        ty_d       = ty_q;
        ox_d       = ox_q;
        oy_d       = oy_q;
        code_d     = code_q;
        frame_d    = frame_q;
        pend_d     = pend_q;
        pend_x_d   = pend_x_q;
        pend_y_d   = pend_y_q;
        map_addr_d = map_addr_q;
        x_d        = x_q;
        y_d        = y_q;
        colour_d   = colour_q;
        we_d       = 1'b0;
        done_d     = (state_q == DONE);
        drop_d     = 1'b0;

        // Requests arriving during a job land in the one-deep slot; newest wins.
        if (state_q != IDLE && req_ok) begin
            pend_d   = 1'b1;
            pend_x_d = bus.tile_x;
            pend_y_d = bus.tile_y;
            drop_d   = pend_q;
        end

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    frame_d    = 1'b1;
                    tx_d       = '0;
                    ty_d       = '0;
                    map_addr_d = '0;
                    state_d    = FETCH;
                end else if (req_ok) begin
                    frame_d    = 1'b0;
                    tx_d       = bus.tile_x;
                    ty_d       = bus.tile_y;
                    map_addr_d = tile_addr(bus.tile_x, bus.tile_y);
                    state_d    = FETCH;
                end
            end
            FETCH: state_d = WAIT;
            WAIT: begin
                code_d  = bus.map_data;
                ox_d    = '0;
                oy_d    = '0;
                state_d = DRAW;
            end
            DRAW: begin
                we_d     = 1'b1;
                x_d      = {tx_q, ox_q};
                y_d      = {ty_q, oy_q};
                colour_d = sprite(code_q, ox_q, oy_q);
                ox_d     = ox_q + 3'd1;
                if (ox_q == 3'd7) begin
                    oy_d = oy_q + 3'd1;
                    if (oy_q == 3'd7) begin
                        if (frame_q && !last_tile) begin
                            tx_d       = (tx_q == 5'(COLS - 1)) ? 5'd0 : tx_q + 5'd1;
                            ty_d       = (tx_q == 5'(COLS - 1)) ? ty_q + 4'd1 : ty_q;
                            map_addr_d = tile_addr(tx_d, ty_d);
                            state_d    = FETCH;
                        end else begin
                            state_d = DONE;
                        end
                    end
                end
            end
            DONE: begin
                if (pend_d) begin
                    frame_d    = 1'b0;
                    tx_d       = pend_x_d;
                    ty_d       = pend_y_d;
                    map_addr_d = tile_addr(pend_x_d, pend_y_d);
                    pend_d     = 1'b0;
                    state_d    = FETCH;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // busy covers the done pulse, which lags the DONE state by a cycle
        busy_d = (state_d != IDLE) || (state_q == DONE);
    end

    always_ff @(posedge clk50M or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            tx_q       <= '0;
            ty_q       <= '0;
            ox_q       <= '0;
            oy_q       <= '0;
            code_q     <= '0;
            frame_q    <= 1'b0;
            pend_q     <= 1'b0;
            pend_x_q   <= '0;
            pend_y_q   <= '0;
            map_addr_q <= '0;
            x_q        <= '0;
            y_q        <= '0;
            colour_q   <= '0;
            we_q       <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            drop_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            tx_q       <= tx_d;
            ty_q       <= ty_d;
            ox_q       <= ox_d;
            oy_q       <= oy_d;
            code_q     <= code_d;
            frame_q    <= frame_d;
            pend_q     <= pend_d;
            pend_x_q   <= pend_x_d;
            pend_y_q   <= pend_y_d;
            map_addr_q <= map_addr_d;
            x_q        <= x_d;
            y_q        <= y_d;
            colour_q   <= colour_d;
            we_q       <= we_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            drop_q     <= drop_d;
        end
    end

    assign bus.map_addr    = map_addr_q;
    assign bus.x_out       = x_q;
    assign bus.y_out       = y_q;
    assign bus.colour_out  = colour_q;
    assign bus.writeEn_out = we_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.req_drop    = drop_q;
endmodule

// File: tb/tb_board_render.sv
// Self-checking bench for board_render: map RAM model, pixel-stream capture and
// a sprite/timing reference model derived from the tile rules.
module tb_board_render;
    logic clk50M = 1'b0;
    logic rst_n  = 1'b0;
    always #10 clk50M = ~clk50M;

    board_render_if bus ();
    board_render dut (.clk50M(clk50M), .rst_n(rst_n), .bus(bus));

    typedef struct {int cyc; int x; int y; int c;} pix_t;

    logic [2:0] map_mem [0:299];
    pix_t got_q[$];
    pix_t exp_q[$];
    int   done_q[$];
    int   drop_cnt = 0;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    always @(posedge clk50M) begin
        cyc <= cyc + 1;
        bus.map_data <= map_mem[bus.map_addr];
    end

    always @(negedge clk50M) begin
        if (bus.writeEn_out === 1'b1)
            got_q.push_back('{cyc, int'(bus.x_out), int'(bus.y_out), int'(bus.colour_out)});
        if (bus.done === 1'b1) done_q.push_back(cyc);
        if (bus.req_drop === 1'b1) drop_cnt++;
    end

    task automatic tick();
        @(negedge clk50M);
        #1;
    endtask

    function automatic int ref_colour(int code, int ox, int oy);
        bit rim  = (ox == 0) || (ox == 7) || (oy == 0) || (oy == 7);
        bit mid  = (ox >= 3) && (ox <= 4) && (oy >= 3) && (oy <= 4);
        bit core = (ox >= 2) && (ox <= 5) && (oy >= 2) && (oy <= 5);
        case (code)
            0: return 0;
            1: return ((oy == 3) || (oy == 7)) ? 7 : 4;
            2: return mid ? 6 : 0;
            3: return rim ? 7 : 6;
            4: return rim ? 7 : 2;
            5: return core ? 1 : 0;
            6: return core ? 3 : 0;
            default: return 5;
        endcase
    endfunction

    task automatic add_tile_exp(input int tx, input int ty, input int first);
        int code = int'(map_mem[ty * 20 + tx]);
        for (int oy = 0; oy < 8; oy++)
            for (int ox = 0; ox < 8; ox++)
                exp_q.push_back('{first + oy * 8 + ox, tx * 8 + ox, ty * 8 + oy,
                                  ref_colour(code, ox, oy)});
    endtask

    // Number of differing stream entries; describes the first one.
    function automatic int stream_diff(output string first);
        int bad = 0;
        first = "";
        if (got_q.size() != exp_q.size()) begin
            bad++;
            first = $sformatf("count %0d want %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            if (got_q[i].cyc != exp_q[i].cyc || got_q[i].x != exp_q[i].x ||
                got_q[i].y != exp_q[i].y || got_q[i].c != exp_q[i].c) begin
                if (bad == 0)
                    first = $sformatf("#%0d got cyc%0d (%0d,%0d) c%0d want cyc%0d (%0d,%0d) c%0d",
                        i, got_q[i].cyc, got_q[i].x, got_q[i].y, got_q[i].c,
                        exp_q[i].cyc, exp_q[i].x, exp_q[i].y, exp_q[i].c);
                bad++;
            end
        end
        return bad;
    endfunction

    task automatic clear_logs();
        got_q.delete();
        exp_q.delete();
        done_q.delete();
        drop_cnt = 0;
    endtask

    task automatic wait_done(input int n, input int budget);
        int t = 0;
        while (done_q.size() < n && t < budget) begin
            tick();
            t++;
        end
    endtask

    task automatic req_tile(input int x, input int y, output int k);
        bus.tile_req = 1'b1;
        bus.tile_x   = 5'(x);
        bus.tile_y   = 4'(y);
        k = cyc + 1;
        tick();
        bus.tile_req = 1'b0;
    endtask

    task automatic pulse_start(output int k);
        bus.start = 1'b1;
        k = cyc + 1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            n_cmp++;
            if ({bus.x_out, bus.y_out, bus.colour_out, bus.writeEn_out, bus.busy,
                 bus.done, bus.req_drop, bus.map_addr} !== 31'd0) begin
                n_bad++;
                $display("FAIL reset_idle cyc%0d: x=%0d y=%0d c=%0d we=%b busy=%b done=%b drop=%b addr=%0d, all must be 0",
                    cyc, bus.x_out, bus.y_out, bus.colour_out, bus.writeEn_out, bus.busy,
                    bus.done, bus.req_drop, bus.map_addr);
            end
        end
    endtask

    task automatic test_single_wall();
        int k;
        string s;
        for (int i = 0; i < 300; i++) map_mem[i] = 3'd1;
        clear_logs();
        req_tile(0, 0, k);
        n_cmp++;
        if (bus.map_addr !== 9'd0 || bus.busy !== 1'b1) begin
            n_bad++;
            $display("FAIL wall_accept: addr=%0d busy=%b, required addr=0 busy=1", bus.map_addr, bus.busy);
        end
        add_tile_exp(0, 0, k + 3);
        wait_done(1, 200);
        n_cmp++;
        if (done_q.size() != 1 || done_q[0] != k + 67) begin
            n_bad++;
            $display("FAIL wall_done: done count %0d at cyc%0d, required 1 at cyc%0d",
                done_q.size(), (done_q.size() > 0) ? done_q[0] : -1, k + 67);
        end
        n_cmp++;
        if (bus.busy !== 1'b1) begin
            n_bad++;
            $display("FAIL wall_busy_during_done: busy=%b required 1", bus.busy);
        end
        tick();
        n_cmp++;
        if (bus.busy !== 1'b0) begin
            n_bad++;
            $display("FAIL wall_busy_after: busy=%b required 0", bus.busy);
        end
        n_cmp++;
        if (got_q.size() != 64 || got_q[24].y != 3 || got_q[24].c != 7 || got_q[0].c != 4) begin
            n_bad++;
            $display("FAIL wall_pixels: n=%0d (0,3)c=%0d (0,0)c=%0d, required 64, 7, 4",
                got_q.size(), (got_q.size() > 24) ? got_q[24].c : -1,
                (got_q.size() > 0) ? got_q[0].c : -1);
        end
        n_cmp++;
        if (stream_diff(s) != 0) begin
            n_bad++;
            $display("FAIL wall_stream: %s", s);
        end
    endtask

    task automatic test_random_tiles();
        int k, x, y;
        string s;
        for (int i = 0; i < 300; i++) map_mem[i] = 3'($urandom_range(0, 7));
        for (int r = 0; r < 6; r++) begin
            clear_logs();
            x = $urandom_range(0, 19);
            y = $urandom_range(0, 14);
            repeat ($urandom_range(1, 4)) tick();
            req_tile(x, y, k);
            n_cmp++;
            if (int'(bus.map_addr) != y * 20 + x) begin
                n_bad++;
                $display("FAIL rand_addr (%0d,%0d): addr=%0d required %0d", x, y, bus.map_addr, y * 20 + x);
            end
            add_tile_exp(x, y, k + 3);
            wait_done(1, 200);
            n_cmp++;
            if (done_q.size() != 1 || done_q[0] != k + 67) begin
                n_bad++;
                $display("FAIL rand_done (%0d,%0d): count %0d, required 1 at cyc%0d", x, y, done_q.size(), k + 67);
            end
            n_cmp++;
            if (stream_diff(s) != 0) begin
                n_bad++;
                $display("FAIL rand_stream (%0d,%0d): %s", x, y, s);
            end
            repeat (2) tick();
        end
    endtask

    task automatic test_frame();
        int k, gap_bad;
        string s;
        for (int i = 0; i < 300; i++) map_mem[i] = 3'(i % 8);
        clear_logs();
        pulse_start(k);
        for (int t = 0; t < 300; t++) add_tile_exp(t % 20, t / 20, k + 3 + t * 66);
        wait_done(1, 20000);
        n_cmp++;
        if (done_q.size() != 1 || done_q[0] != k + 19801) begin
            n_bad++;
            $display("FAIL frame_done: count %0d, required 1 at cyc%0d", done_q.size(), k + 19801);
        end
        n_cmp++;
        if (got_q.size() != 19200 || got_q[19199].x != 159 || got_q[19199].y != 119 ||
            got_q[19199].cyc != k + 19800) begin
            n_bad++;
            $display("FAIL frame_last: n=%0d, required 19200 ending (159,119) at cyc%0d", got_q.size(), k + 19800);
        end else begin
            n_cmp++;
            if (got_q[192].x != 24 || got_q[192].y != 0 || got_q[192].c != 7 ||
                got_q[201].x != 25 || got_q[201].y != 1 || got_q[201].c != 6) begin
                n_bad++;
                $display("FAIL frame_box: (24,0)c=%0d (25,1)c=%0d, required 7 and 6", got_q[192].c, got_q[201].c);
            end
            gap_bad = 0;
            for (int i = 1; i < got_q.size(); i++) begin
                if ((i % 64 == 0) != (got_q[i].cyc - got_q[i - 1].cyc == 3)) gap_bad++;
                else if (i % 64 != 0 && got_q[i].cyc - got_q[i - 1].cyc != 1) gap_bad++;
            end
            n_cmp++;
            if (gap_bad != 0) begin
                n_bad++;
                $display("FAIL frame_gaps: %0d misplaced gaps, required 0", gap_bad);
            end
        end
        n_cmp++;
        if (stream_diff(s) != 0) begin
            n_bad++;
            $display("FAIL frame_stream: %s", s);
        end
        repeat (2) tick();
        n_cmp++;
        if (bus.busy !== 1'b0) begin
            n_bad++;
            $display("FAIL frame_idle: busy=%b required 0", bus.busy);
        end
    endtask

    task automatic test_drop_and_ignore();
        int k, kd, dummy;
        string s;
        for (int i = 0; i < 300; i++) map_mem[i] = 3'($urandom_range(0, 7));
        clear_logs();
        pulse_start(k);
        repeat (1000) tick();
        req_tile(5, 5, dummy);
        repeat (200) tick();
        pulse_start(dummy);
        repeat (100) tick();
        req_tile(6, 6, dummy);
        repeat (50) tick();
        req_tile(25, 3, dummy);
        for (int t = 0; t < 300; t++) add_tile_exp(t % 20, t / 20, k + 3 + t * 66);
        wait_done(1, 20000);
        kd = k + 19801;
        n_cmp++;
        if (done_q.size() != 1 || done_q[0] != kd || bus.map_addr !== 9'd126) begin
            n_bad++;
            $display("FAIL drop_chain: done count %0d addr=%0d, required done at cyc%0d addr=126",
                done_q.size(), bus.map_addr, kd);
        end
        add_tile_exp(6, 6, kd + 3);
        wait_done(2, 200);
        n_cmp++;
        if (done_q.size() != 2 || done_q[1] != kd + 67) begin
            n_bad++;
            $display("FAIL drop_second_done: count %0d, required 2nd at cyc%0d", done_q.size(), kd + 67);
        end
        repeat (100) tick();
        n_cmp++;
        if (drop_cnt != 1 || done_q.size() != 2) begin
            n_bad++;
            $display("FAIL drop_count: drops=%0d dones=%0d, required 1 and 2", drop_cnt, done_q.size());
        end
        n_cmp++;
        if (stream_diff(s) != 0) begin
            n_bad++;
            $display("FAIL drop_stream: %s", s);
        end
    endtask

    task automatic test_priority();
        int k, seen_busy;
        bus.start    = 1'b1;
        bus.tile_req = 1'b1;
        bus.tile_x   = 5'd2;
        bus.tile_y   = 4'd2;
        clear_logs();
        k = cyc + 1;
        tick();
        bus.start    = 1'b0;
        bus.tile_req = 1'b0;
        wait_done(1, 20000);
        repeat (150) tick();
        n_cmp++;
        if (done_q.size() != 1 || got_q.size() != 19200 || drop_cnt != 0 || done_q[0] != k + 19801) begin
            n_bad++;
            $display("FAIL prio_frame_only: dones=%0d writes=%0d drops=%0d, required 1, 19200, 0",
                done_q.size(), got_q.size(), drop_cnt);
        end
        clear_logs();
        seen_busy = 0;
        req_tile(20, 0, k);
        req_tile(3, 15, k);
        for (int i = 0; i < 20; i++) begin
            if (bus.busy !== 1'b0) seen_busy++;
            tick();
        end
        n_cmp++;
        if (seen_busy != 0 || done_q.size() != 0 || got_q.size() != 0 || drop_cnt != 0) begin
            n_bad++;
            $display("FAIL range_ignore: busy cycles=%0d dones=%0d writes=%0d drops=%0d, required all 0",
                seen_busy, done_q.size(), got_q.size(), drop_cnt);
        end
    endtask

    task automatic test_reset_mid();
        int k, t;
        string s;
        for (int i = 0; i < 300; i++) map_mem[i] = 3'($urandom_range(0, 7));
        clear_logs();
        pulse_start(k);
        t = 0;
        while (got_q.size() < 5000 && t < 6000) begin
            tick();
            t++;
        end
        n_cmp++;
        if (got_q.size() < 5000) begin
            n_bad++;
            $display("FAIL mid_progress: writes=%0d, required 5000", got_q.size());
        end
        #3;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({bus.x_out, bus.y_out, bus.colour_out, bus.writeEn_out, bus.busy,
             bus.done, bus.req_drop, bus.map_addr} !== 31'd0) begin
            n_bad++;
            $display("FAIL mid_reset: x=%0d y=%0d c=%0d we=%b busy=%b addr=%0d, all must be 0",
                bus.x_out, bus.y_out, bus.colour_out, bus.writeEn_out, bus.busy, bus.map_addr);
        end
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        clear_logs();
        req_tile(1, 1, k);
        n_cmp++;
        if (bus.map_addr !== 9'd21) begin
            n_bad++;
            $display("FAIL post_reset_addr: addr=%0d required 21", bus.map_addr);
        end
        add_tile_exp(1, 1, k + 3);
        wait_done(1, 200);
        n_cmp++;
        if (done_q.size() != 1 || done_q[0] != k + 67) begin
            n_bad++;
            $display("FAIL post_reset_done: count %0d, required 1 at cyc%0d", done_q.size(), k + 67);
        end
        n_cmp++;
        if (stream_diff(s) != 0) begin
            n_bad++;
            $display("FAIL post_reset_stream: %s", s);
        end
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached at cyc%0d", cyc);
        $fatal(1, "time limit");
    end

    initial begin
        bus.start    = 1'b0;
        bus.tile_req = 1'b0;
        bus.tile_x   = '0;
        bus.tile_y   = '0;
        for (int i = 0; i < 300; i++) map_mem[i] = 3'd0;
        test_reset();
        test_single_wall();
        test_random_tiles();
        test_frame();
        test_drop_and_ignore();
        test_priority();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
